// File: rtl/hsv_core_flush_ctrl.sv
// hsv_core_flush_ctrl
// Initiator side of the core flush req/ack handshake. Broadcasts flush_req to
// all execution units, waits for every unit to acknowledge entry and then to
// release, and finishes with a one-cycle fetch redirect to the captured PC.
// A flush toward RESET_PC is forced out of reset.
//
// Build option: define HSV_FLUSH_TIMEOUT_EN to add a per-phase watchdog that
// raises sticky timeout_error; without it timeout_error is tied low.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no flush in progress; trigger accepted here only
// ST_ENTER    | flush_req high; waiting for every unit to acknowledge
// ST_EXIT     | flush_req low; waiting for every unit to drop its ack
// ST_REDIRECT | one-cycle redirect pulse to redirect_pc, then back to idle
module hsv_core_flush_ctrl #(
    parameter int          NUM_UNITS = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk_core,
    input  logic                 rst_core_n,
    input  logic                 trigger_valid,
    output logic                 trigger_ready,
    input  logic [31:0]          trigger_pc,
    output logic                 flush_req,
    input  logic [NUM_UNITS-1:0] flush_ack,
    output logic                 flushing,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 proto_error,
    output logic                 timeout_error
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTER    = 2'd1,
        ST_EXIT     = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   all_ack;
    logic   any_ack;

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (NUM_UNITS < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("hsv_core_flush_ctrl: need NUM_UNITS >= 1 and TIMEOUT in 1..255");
    end

    assign all_ack = &flush_ack;
    assign any_ack = |flush_ack;

    // State register; reset always restarts a flush from ENTER.
    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            state <= ST_ENTER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: progress depends only on the AND/OR of the unit acks.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (trigger_valid) state_next = ST_ENTER;
            ST_ENTER:    if (all_ack)       state_next = ST_EXIT;
            ST_EXIT:     if (!any_ack)      state_next = ST_REDIRECT;
            ST_REDIRECT:                    state_next = ST_IDLE;
            default:                        state_next = ST_ENTER;
        endcase
    end

    // Outputs are pure decodes of the state, so flush_req drops on the same
    // edge that moves ENTER to EXIT.
    always_comb begin
        trigger_ready  = 1'b0;
        flushing       = 1'b1;
        flush_req      = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                trigger_ready = 1'b1;
                flushing      = 1'b0;
            end
            ST_ENTER:    flush_req      = 1'b1;
            ST_REDIRECT: redirect_valid = 1'b1;
            default: ;
        endcase
    end

    // Target capture on accept and the sticky protocol-violation flag. An ack
    // while idle or redirecting is recorded but never steers the FSM.
    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            redirect_pc <= RESET_PC;
            proto_error <= 1'b0;
        end else begin
            if (state == ST_IDLE && trigger_valid) begin
                redirect_pc <= trigger_pc;
            end
            if ((state == ST_IDLE || state == ST_REDIRECT) && any_ack) begin
                proto_error <= 1'b1;
            end
        end
    end

`ifdef HSV_FLUSH_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] phase_cnt;
    logic       waiting;

    assign waiting = (state == ST_ENTER) || (state == ST_EXIT);

    // Watchdog: counts cycles spent in one wait phase and flags the phase
    // that reaches TIMEOUT; the FSM itself keeps waiting.
    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            phase_cnt     <= '0;
            timeout_error <= 1'b0;
        end else begin
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (waiting && phase_cnt != 8'hFF) begin
                phase_cnt <= phase_cnt + 8'd1;
            end
            if (waiting && state_next == state && phase_cnt == CNT_LAST) begin
                timeout_error <= 1'b1;
            end
        end
    end
`else
    assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// tb_hsv_core_flush_ctrl
// Scoreboard bench for hsv_core_flush_ctrl. Each issued trigger (or reset) is
// turned into a flush record: ENTER/EXIT/REDIRECT cycle windows computed from
// the per-unit ack delays. Expected redirects are queued; a negedge monitor
// compares every cycle against the record timeline and pops a redirect
// whenever the DUT pulses one.
module tb_hsv_core_flush_ctrl;

    localparam int          NUM_UNITS = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          TIMEOUT   = 255;
    localparam int          BIG       = 32'h3fff_ffff;

    localparam int PH_IDLE  = 0;
    localparam int PH_ENTER = 1;
    localparam int PH_EXIT  = 2;
    localparam int PH_RED   = 3;

    logic                 clk_core;
    logic                 rst_core_n;
    logic                 trigger_valid;
    logic                 trigger_ready;
    logic [31:0]          trigger_pc;
    logic                 flush_req;
    logic [NUM_UNITS-1:0] flush_ack;
    logic                 flushing;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 proto_error;
    logic                 timeout_error;

    hsv_core_flush_ctrl #(
        .NUM_UNITS(NUM_UNITS),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_core      (clk_core),
        .rst_core_n    (rst_core_n),
        .trigger_valid (trigger_valid),
        .trigger_ready (trigger_ready),
        .trigger_pc    (trigger_pc),
        .flush_req     (flush_req),
        .flush_ack     (flush_ack),
        .flushing      (flushing),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .proto_error   (proto_error),
        .timeout_error (timeout_error)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int cyc = 0;
    always @(posedge clk_core) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        int          s;
        int          e;
        int          r;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } redir_t;

    rec_t   rec_q[$];
    redir_t redir_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int idle_from = BIG;
    int drop_cyc  = 0;
    logic exp_proto = 1'b0;
    logic exp_to    = 1'b0;

    int rise_d[NUM_UNITS];
    int fall_d[NUM_UNITS];
    logic [NUM_UNITS-1:0] force1 = '0;
    logic [NUM_UNITS-1:0] force0 = '0;

    // ---------------- behavioural unit model ----------------
    // Each unit raises its ack once req has been high for rise_d cycles and
    // drops it once req has been low for fall_d cycles; units share the reset.
    initial begin
        logic                 last_req;
        int                   age;
        logic [NUM_UNITS-1:0] nxt;
        last_req  = 1'b0;
        age       = 0;
        nxt       = '0;
        flush_ack = '0;
        forever begin
            @(negedge clk_core);
            if (rst_core_n !== 1'b1) begin
                last_req = 1'b0;
                age      = 0;
                nxt      = '0;
            end else begin
                if (flush_req === last_req) begin
                    age++;
                end else begin
                    last_req = flush_req;
                    age      = 1;
                end
                for (int i = 0; i < NUM_UNITS; i++) begin
                    if (force1[i])                          nxt[i] = 1'b1;
                    else if (force0[i])                     nxt[i] = 1'b0;
                    else if (last_req && age >= rise_d[i])  nxt[i] = 1'b1;
                    else if (!last_req && age >= fall_d[i]) nxt[i] = 1'b0;
                end
            end
            @(posedge clk_core);
            #1;
            flush_ack = nxt;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic int max_rise();
        int m = 0;
        for (int i = 0; i < NUM_UNITS; i++) if (rise_d[i] > m) m = rise_d[i];
        return m;
    endfunction

    function automatic int max_fall();
        int m = 0;
        for (int i = 0; i < NUM_UNITS; i++) if (fall_d[i] > m) m = fall_d[i];
        return m;
    endfunction

    function automatic int phase_at(input int c, output int pstart);
        pstart = 0;
        foreach (rec_q[i]) begin
            if (c >= rec_q[i].s && c < rec_q[i].e) begin
                pstart = rec_q[i].s;
                return PH_ENTER;
            end
            if (c >= rec_q[i].e && c < rec_q[i].r) begin
                pstart = rec_q[i].e;
                return PH_EXIT;
            end
            if (c == rec_q[i].r) return PH_RED;
        end
        return PH_IDLE;
    endfunction

    // A flush starting in cycle s: all acks high after max_rise cycles, one
    // more cycle to leave ENTER; likewise for EXIT; then one redirect cycle.
    task automatic add_record(input logic [31:0] pc, input int s, output int e);
        rec_t   rc;
        redir_t rd;
        rc.pc = pc;
        rc.s  = s;
        rc.e  = s + max_rise() + 1;
        rc.r  = rc.e + max_fall() + 1;
        rec_q.push_back(rc);
        rd.pc  = pc;
        rd.cyc = rc.r;
        redir_q.push_back(rd);
        idle_from = rc.r + 1;
        e = rc.e;
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
        if (trigger_valid && cyc > drop_cyc) trigger_valid = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < idle_from) tick();
    endtask

    task automatic issue_trigger(input logic [31:0] pc, output int e);
        int a;
        a = (cyc > idle_from) ? cyc : idle_from;
        add_record(pc, a + 1, e);
        drop_cyc      = a;
        trigger_valid = 1'b1;
        trigger_pc    = pc;
    endtask

    task automatic reset_for(input int n);
        int e;
        rst_core_n    = 1'b0;
        trigger_valid = 1'b0;
        rec_q.delete();
        redir_q.delete();
        add_record(RESET_PC, cyc + n, e);
        repeat (n) tick();
        rst_core_n = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_core) begin
        int     ph;
        int     pst;
        redir_t rd;
        if (rst_core_n !== 1'b1) begin
            exp_proto = 1'b0;
            exp_to    = 1'b0;
        end else begin
            while (rec_q.size() > 0 && rec_q[0].r < cyc) void'(rec_q.pop_front());
            ph = phase_at(cyc, pst);
            chk("trigger_ready",  32'(trigger_ready),  32'(ph == PH_IDLE));
            chk("flushing",       32'(flushing),       32'(ph != PH_IDLE));
            chk("flush_req",      32'(flush_req),      32'(ph == PH_ENTER));
            chk("redirect_valid", 32'(redirect_valid), 32'(ph == PH_RED));
            chk("proto_error",    32'(proto_error),    32'(exp_proto));
            chk("timeout_error",  32'(timeout_error),  32'(exp_to));

            if (redir_q.size() > 0 && redir_q[0].cyc < cyc) begin
                rd = redir_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL redirect_missing at cycle %0d: no pulse, expected one at cycle %0d pc 0x%08h",
                         cyc, rd.cyc, rd.pc);
            end
            if (redirect_valid === 1'b1) begin
                if (redir_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL redirect_unexpected at cycle %0d: got pc 0x%08h, expected no pulse",
                             cyc, redirect_pc);
                end else begin
                    rd = redir_q.pop_front();
                    chk("redirect_pc",    redirect_pc, rd.pc);
                    chk("redirect_cycle", 32'(cyc),    32'(rd.cyc));
                end
            end

            if ((ph == PH_IDLE || ph == PH_RED) && (|flush_ack)) exp_proto = 1'b1;
`ifdef HSV_FLUSH_TIMEOUT_EN
            if ((ph == PH_ENTER || ph == PH_EXIT) && (cyc - pst + 1) >= TIMEOUT) exp_to = 1'b1;
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int e2;
        int gap;
        rst_core_n    = 1'b0;
        trigger_valid = 1'b0;
        trigger_pc    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            rise_d[i] = 1;
            fall_d[i] = 1;
        end

        // Post-reset flush to RESET_PC, acks one cycle behind req.
        tick();
        reset_for(3);
        wait_idle();
        tick();

        // Plain trigger: redirect in cycle 5 after accept.
        issue_trigger(32'h8000_0040, e);
        wait_idle();
        tick();

        // One slow unit in ENTER stretches the flush by exactly 10 cycles.
        rise_d[2] = 11;
        issue_trigger(32'h0000_5a5c, e);
        wait_idle();
        rise_d[2] = 1;
        tick();

        // Second trigger raised during EXIT waits for IDLE.
        issue_trigger(32'h0000_2000, e);
        while (cyc < e) tick();
        issue_trigger(32'h0000_0100, e2);
        wait_idle();
        tick();

        // Reset pulse during EXIT abandons the flush and any pending trigger.
        issue_trigger(32'h1234_5670, e);
        while (cyc < e) tick();
        issue_trigger(32'hdead_bee0, e2);
        tick();
        reset_for(1);
        wait_idle();
        tick(); tick();

        // Stray ack while idle sets the sticky protocol error.
        force1[0] = 1'b1;
        tick(); tick();
        force1[0] = 1'b0;
        repeat (3) tick();
        issue_trigger(32'h0000_0f00, e);
        wait_idle();

        // Randomized flushes with random per-unit ack delays.
        for (int k = 0; k < 40; k++) begin
            while (trigger_valid) tick();
            if (k > 0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) tick();
            end else begin
                gap = $urandom_range(0, 3);
                while (cyc < idle_from + gap) tick();
                for (int i = 0; i < NUM_UNITS; i++) begin
                    rise_d[i] = $urandom_range(1, 6);
                    fall_d[i] = $urandom_range(1, 6);
                end
            end
            issue_trigger($urandom, e);
        end
        wait_idle();
        tick();
        for (int i = 0; i < NUM_UNITS; i++) begin
            rise_d[i] = 1;
            fall_d[i] = 1;
        end

        // Only reset clears the protocol error.
        reset_for(1);
        wait_idle();
        tick();

`ifdef HSV_FLUSH_TIMEOUT_EN
        // One unit never acks: watchdog fires TIMEOUT cycles into ENTER.
        begin
            rec_t rc;
            force0[1] = 1'b1;
            rc.pc = 32'hcafe_0000;
            rc.s  = cyc + 1;
            rc.e  = BIG;
            rc.r  = BIG;
            rec_q.push_back(rc);
            idle_from     = BIG;
            drop_cyc      = cyc;
            trigger_valid = 1'b1;
            trigger_pc    = rc.pc;
            repeat (TIMEOUT + 8) tick();
            force0[1] = 1'b0;
            reset_for(1);
            wait_idle();
            tick();
        end
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
